// File: rtl/fir_pkg.sv
// Shared widths, FSM state encoding and tap index type for the sequential FIR.
package fir_pkg;

  localparam int DATA_W   = 17;
  localparam int COEF_W   = 17;
  localparam int OUT_W    = 36;
  localparam int NUM_TAPS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  typedef logic [1:0] tap_idx_t;

endpackage

// File: rtl/fir_mul.sv
// Combinational signed multiplier; product is sign-extended to the accumulator width.
module fir_mul #(
  parameter int A_W = 17,
  parameter int B_W = 17,
  parameter int P_W = 36
) (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] p
);

  logic signed [A_W+B_W-1:0] prod;

  // Full-precision signed product, then sign-extend to the output width.
  always_comb begin
    prod = $signed(a) * $signed(b);
    p    = {{(P_W-A_W-B_W){prod[A_W+B_W-1]}}, prod};
  end

endmodule

// File: rtl/fir_seq_mac.sv
// 4-tap direct-form FIR time-multiplexed onto one multiplier and one accumulator.
// Samples enter over in_valid/in_ready, results leave over out_valid/out_ready.
import fir_pkg::*;

module fir_seq_mac #(
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int COEF_W = fir_pkg::COEF_W,
  parameter int OUT_W  = fir_pkg::OUT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  input  logic [COEF_W-1:0] c0,
  input  logic [COEF_W-1:0] c1,
  input  logic [COEF_W-1:0] c2,
  input  logic [COEF_W-1:0] c3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  y_out
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] x_q    [NUM_TAPS];
  logic [DATA_W-1:0] x_d    [NUM_TAPS];
  logic [COEF_W-1:0] coef_q [NUM_TAPS];
  logic [COEF_W-1:0] coef_d [NUM_TAPS];
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]  y_q, y_d;
  tap_idx_t          idx_q, idx_d;
  logic              done_q, done_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W-1:0] mul_a;
  logic [COEF_W-1:0] mul_b;
  logic [OUT_W-1:0]  prod;

  fir_mul #(
    .A_W(DATA_W),
    .B_W(COEF_W),
    .P_W(OUT_W)
  ) u_mul (
    .a(mul_a),
    .b(mul_b),
    .p(prod)
  );

  // Select the operand pair for the tap currently being accumulated.
  always_comb begin
    mul_a = x_q[idx_q];
    mul_b = coef_q[idx_q];
  end

  // Next-state, datapath and handshake flag computation.
  // done_q marks that all four taps are summed; the following MAC cycle moves
  // the finished sum into y_out, giving out_valid five edges after accept.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    coef_d  = coef_q;
    acc_d   = acc_q;
    y_d     = y_q;
    idx_d   = idx_q;
    done_d  = done_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d[3]    = x_q[2];
          x_d[2]    = x_q[1];
          x_d[1]    = x_q[0];
          x_d[0]    = x_in;
          coef_d[0] = c0;
          coef_d[1] = c1;
          coef_d[2] = c2;
          coef_d[3] = c3;
          acc_d     = '0;
          idx_d     = '0;
          done_d    = 1'b0;
          state_d   = MAC;
        end
      end
      MAC: begin
        if (done_q) begin
          y_d     = acc_q;
          done_d  = 1'b0;
          state_d = OUT;
        end else begin
          acc_d = acc_q + prod;
          idx_d = tap_idx_t'(idx_q + 2'd1);
          if (idx_q == 2'd3) begin
            done_d = 1'b1;
          end
        end
      end
      OUT: begin
        if (out_ready && out_valid_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == OUT);
  end

  // State, history, coefficient, accumulator and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      y_q         <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        x_q[i]    <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        x_q[i]    <= x_d[i];
        coef_q[i] <= coef_d[i];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y_out     = y_q;

endmodule
